// File: rtl/temporal_decoder.sv
// temporal_decoder
//   Converts a race-logic spike into a binary arrival time. A gamma window is
//   opened by gamma_start. The block then counts aclk ticks until a rising
//   transition appears on spike_in, which is the q output of the upstream
//   exclusive_min stage. The tick count is presented on a valid/ready port.
//   If no rising transition arrives within WINDOW ticks, the infinity code
//   (WINDOW, with out_none=1) is presented instead.
//
// Ports
//   aclk        in   single clock
//   grst        in   asynchronous active-low reset
//   gamma_start in   one-cycle pulse, opens (or restarts) a window
//   spike_in    in   level from upstream q; only 0->1 transitions count
//   out_time    out  arrival tick, or WINDOW when no spike arrived
//   out_none    out  high alongside out_valid when no spike arrived
//   out_valid   out  result available
//   out_ready   in   consumer accepts the result
//   overrun     out  sticky; a held result was replaced before acceptance
//
// All outputs come straight from flops.
module temporal_decoder #(
  parameter int CNT_W  = 4,
  parameter int WINDOW = 15
) (
  input  logic             aclk,
  input  logic             grst,
  input  logic             gamma_start,
  input  logic             spike_in,
  output logic [CNT_W-1:0] out_time,
  output logic             out_none,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  // Reject window lengths that cannot be encoded or that leave no tick for a spike.
  if ((WINDOW < 2) || (WINDOW > ((2 ** CNT_W) - 1))) begin : g_bad_window
    $error("temporal_decoder: WINDOW out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_INF  = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Increment that cannot pass the last tick of the window.
  function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value < CNT_LAST) begin
      result = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      result = CNT_LAST;
    end
    return result;
  endfunction

  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nx_s;
  logic             spike_prev_r;
  logic             spike_prev_nx_s;
  logic [CNT_W-1:0] time_r;
  logic [CNT_W-1:0] time_nx_s;
  logic             none_r;
  logic             none_nx_s;
  logic             valid_r;
  logic             overrun_r;
  logic             overrun_nx_s;
  logic             edge_s;

  // A rising transition is the current level high with the previous sample low.
  assign edge_s = spike_in & ~spike_prev_r;

  // Next-state and next-result logic for the IDLE/COUNT/HOLD sequence.
  always_comb begin
    state_nx_s      = state_r;
    count_nx_s      = count_r;
    spike_prev_nx_s = spike_prev_r;
    time_nx_s       = time_r;
    none_nx_s       = none_r;
    overrun_nx_s    = overrun_r;

    case (state_r)
      IDLE: begin
        // spike_in is ignored here; only the window opening samples it, so a
        // level that is already high is not mistaken for an edge.
        if (gamma_start) begin
          state_nx_s      = COUNT;
          count_nx_s      = CNT_ZERO;
          spike_prev_nx_s = spike_in;
        end else begin
          state_nx_s = IDLE;
        end
      end

      COUNT: begin
        spike_prev_nx_s = spike_in;
        if (gamma_start) begin
          // Restart wins over an edge seen on the same cycle.
          state_nx_s = COUNT;
          count_nx_s = CNT_ZERO;
        end else if (edge_s) begin
          state_nx_s = HOLD;
          time_nx_s  = count_r;
          none_nx_s  = 1'b0;
        end else if (count_r == CNT_LAST) begin
          state_nx_s = HOLD;
          time_nx_s  = CNT_INF;
          none_nx_s  = 1'b1;
        end else begin
          count_nx_s = count_inc(count_r);
        end
      end

      HOLD: begin
        if (gamma_start) begin
          // A transfer on this same edge counts as accepted, so only an
          // unaccepted result raises overrun.
          state_nx_s      = COUNT;
          count_nx_s      = CNT_ZERO;
          spike_prev_nx_s = spike_in;
          overrun_nx_s    = overrun_r | ~out_ready;
        end else if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = HOLD;
        end
      end

      default: begin
        state_nx_s      = IDLE;
        count_nx_s      = CNT_ZERO;
        spike_prev_nx_s = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs. out_valid is derived from the next
  // state, so it reads high exactly while the machine sits in HOLD.
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      state_r      <= IDLE;
      count_r      <= CNT_ZERO;
      spike_prev_r <= 1'b0;
      time_r       <= CNT_ZERO;
      none_r       <= 1'b0;
      valid_r      <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      count_r      <= count_nx_s;
      spike_prev_r <= spike_prev_nx_s;
      time_r       <= time_nx_s;
      none_r       <= none_nx_s;
      valid_r      <= (state_nx_s == HOLD);
      overrun_r    <= overrun_nx_s;
    end
  end

  assign out_time  = time_r;
  assign out_none  = none_r;
  assign out_valid = valid_r;
  assign overrun   = overrun_r;

endmodule
